// File: rtl/my_not_if.sv
// my_not_if: bundles the data and status signals of the my_not inverter cell.
//   in1         - data word to invert (driven by the producer)
//   in_valid    - qualifies in1 for capture into the registered pipeline
//   out         - combinational inverse of in1
//   out_q       - registered inverse of in1, delayed by the pipeline depth
//   out_q_valid - out_q holds a newly delivered word this cycle
//   toggle_cnt  - saturating count of delivered words that changed out_q
// The master modport is the producer/consumer side, the slave modport the cell.
interface my_not_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] in1;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             out_q_valid;
  logic [CNT_W-1:0] toggle_cnt;

  modport master (
    output in1,
    output in_valid,
    input  out,
    input  out_q,
    input  out_q_valid,
    input  toggle_cnt
  );

  modport slave (
    input  in1,
    input  in_valid,
    output out,
    output out_q,
    output out_q_valid,
    output toggle_cnt
  );
endinterface

// File: rtl/my_not.sv
// my_not: bitwise inverter with a combinational output and a registered copy.
//   clk   - rising-edge clock, used by the registered path only
//   rst_n - asynchronous active-low reset, registered path only
//   bus   - my_not_if slave: in1/in_valid in; out, out_q, out_q_valid,
//           toggle_cnt out
// out = ~in1 with no register in the path. The registered path is a STAGES-deep
// pipeline of ~in1 with a valid bit per stage; data in a stage only moves when
// the stage feeding it is valid, so out_q holds its last delivered word. The
// toggle counter counts deliveries to the last stage that change out_q and
// saturates at all-ones.
module my_not #(
  parameter int WIDTH  = 1,  // 1..64
  parameter int STAGES = 1,  // 1..4
  parameter int CNT_W  = 8
) (
  input logic     clk,
  input logic     rst_n,
  my_not_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0]  data_q, data_d;
  // What each stage would load this edge: stage 0 sees the input, stage k
  // sees stage k-1.
  logic [STAGES-1:0]             up_valid;
  logic [STAGES-1:0][WIDTH-1:0]  up_data;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  // Primary function: pure combinational inversion, independent of clk/rst_n.
  assign bus.out = ~bus.in1;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    up_valid = '0;
    up_data  = '0;
    up_valid[0] = bus.in_valid;
    up_data[0]  = ~bus.in1;
    for (int k = 1; k < STAGES; k++) begin
      up_valid[k] = valid_q[k-1];
      up_data[k]  = data_q[k-1];
    end

    // Valid bits advance every edge; data only moves behind a valid bit.
    valid_d = up_valid;
    data_d  = data_q;
    for (int k = 0; k < STAGES; k++) begin
      if (up_valid[k]) data_d[k] = up_data[k];
    end

    // Count a delivery into the last stage only if it changes out_q.
    cnt_d = cnt_q;
    if (up_valid[STAGES-1] && (up_data[STAGES-1] != data_q[STAGES-1]) &&
        (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data stages are reset too, not just the valid bits, because
      // out_q must read 0 during reset and the first delivered word is
      // compared against that 0 by the toggle counter.
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge
      // value of its upstream neighbour regardless of statement order.
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_q       = data_q[STAGES-1];
  assign bus.out_q_valid = valid_q[STAGES-1];
  assign bus.toggle_cnt  = cnt_q;

endmodule

// File: tb/tb_my_not.sv
// tb_my_not: self-checking bench for my_not. Two instances:
//   u_a: WIDTH=8, STAGES=2, CNT_W=8
//   u_b: WIDTH=1, STAGES=1, CNT_W=2 (exercises counter saturation)
// A behavioural model per instance treats the pipeline as a plain delay of
// STAGES-1 edges on the stream of (in_valid, ~in1) samples; a compare process
// checks every cycle, and directed literal checks pin the model.
module tb_my_not;

  localparam int A_W = 8, A_S = 2, A_C = 8;
  localparam int B_W = 1, B_S = 1, B_C = 2;
  localparam int A_MAX = (1 << A_C) - 1;
  localparam int B_MAX = (1 << B_C) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   clk_run = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  my_not_if #(.WIDTH(A_W), .CNT_W(A_C)) bus_a ();
  my_not_if #(.WIDTH(B_W), .CNT_W(B_C)) bus_b ();

  my_not #(.WIDTH(A_W), .STAGES(A_S), .CNT_W(A_C)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  my_not #(.WIDTH(B_W), .STAGES(B_S), .CNT_W(B_C)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  // Clock stays idle until the no-clock combinational checks are done.
  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          v;
    logic [63:0] d;
  } samp_t;

  samp_t       qa[$];
  logic [63:0] ea_q;
  bit          ea_v;
  int          ea_cnt;

  samp_t       qb[$];
  logic [63:0] eb_q;
  bit          eb_v;
  int          eb_cnt;

  // A word sampled at edge N is delivered at edge N+STAGES-1: hold the last
  // STAGES-1 samples in a queue and deliver whatever falls out of it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      ea_q = '0; ea_v = 1'b0; ea_cnt = 0;
    end else begin
      samp_t s;
      logic [A_W-1:0] inv;
      inv = ~bus_a.in1;
      s.v = bus_a.in_valid;
      s.d = 64'(inv);
      qa.push_back(s);
      if (qa.size() > A_S - 1) begin
        s = qa.pop_front();
        ea_v = s.v;
        if (s.v) begin
          if (s.d != ea_q && ea_cnt < A_MAX) ea_cnt++;
          ea_q = s.d;
        end
      end else begin
        ea_v = 1'b0;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qb.delete();
      eb_q = '0; eb_v = 1'b0; eb_cnt = 0;
    end else begin
      samp_t s;
      logic [B_W-1:0] inv;
      inv = ~bus_b.in1;
      s.v = bus_b.in_valid;
      s.d = 64'(inv);
      qb.push_back(s);
      if (qb.size() > B_S - 1) begin
        s = qb.pop_front();
        eb_v = s.v;
        if (s.v) begin
          if (s.d != eb_q && eb_cnt < B_MAX) eb_cnt++;
          eb_q = s.d;
        end
      end else begin
        eb_v = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    logic [A_W-1:0] ia;
    logic [B_W-1:0] ib;
    #2;
    ia = ~bus_a.in1;
    ib = ~bus_b.in1;
    check("a_out",       64'(bus_a.out),         64'(ia));
    check("a_out_q",     64'(bus_a.out_q),       64'(ea_q[A_W-1:0]));
    check("a_out_q_vld", 64'(bus_a.out_q_valid), 64'(ea_v));
    check("a_tgl_cnt",   64'(bus_a.toggle_cnt),  64'(ea_cnt));
    check("b_out",       64'(bus_b.out),         64'(ib));
    check("b_out_q",     64'(bus_b.out_q),       64'(eb_q[B_W-1:0]));
    check("b_out_q_vld", 64'(bus_b.out_q_valid), 64'(eb_v));
    check("b_tgl_cnt",   64'(bus_b.toggle_cnt),  64'(eb_cnt));
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bus_a.in1 = '0; bus_a.in_valid = 1'b0;
    bus_b.in1 = '0; bus_b.in_valid = 1'b0;

    // No clock, reset asserted: combinational path only.
    bus_b.in1 = 1'b0;
    #10 check("t1_out_in0", 64'(bus_b.out), 64'h1);
    bus_b.in1 = 1'b1;
    #10 check("t1_out_in1", 64'(bus_b.out), 64'h0);

    bus_a.in1 = 8'hA5;
    #1;
    check("t2_out",     64'(bus_a.out),         64'h5A);
    check("t2_out_q",   64'(bus_a.out_q),       64'h00);
    check("t2_out_vld", 64'(bus_a.out_q_valid), 64'h0);
    check("t2_cnt",     64'(bus_a.toggle_cnt),  64'h0);

    // Start clock, release reset on a falling edge.
    clk_run = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word through the 2-stage pipeline.
    bus_a.in1 = 8'h0F; bus_a.in_valid = 1'b1;
    @(negedge clk);
    check("t3_vld_edgeN", 64'(bus_a.out_q_valid), 64'h0);
    bus_a.in_valid = 1'b0; bus_a.in1 = 8'h33;
    @(negedge clk);
    check("t3_out_q",     64'(bus_a.out_q),       64'hF0);
    check("t3_vld",       64'(bus_a.out_q_valid), 64'h1);
    @(negedge clk);
    check("t3_vld_drop",  64'(bus_a.out_q_valid), 64'h0);
    check("t3_out_hold",  64'(bus_a.out_q),       64'hF0);
    check("t3_cnt",       64'(bus_a.toggle_cnt),  64'h1);

    // Same word twice: only the first delivery changes out_q.
    bus_a.in1 = 8'hFF; bus_a.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    check("t4_out_q", 64'(bus_a.out_q),       64'h00);
    check("t4_vld",   64'(bus_a.out_q_valid), 64'h1);
    check("t4_cnt",   64'(bus_a.toggle_cnt),  64'h2);
    @(negedge clk);
    check("t4_cnt_hold", 64'(bus_a.toggle_cnt), 64'h2);

    // CNT_W=2 saturation: five alternating words, all changing out_q.
    bus_b.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_b.in1 = 1'(i);
      @(negedge clk);
      if (i == 1) check("t5_cnt_mid", 64'(bus_b.toggle_cnt), 64'h2);
    end
    bus_b.in_valid = 1'b0;
    check("t5_cnt_sat", 64'(bus_b.toggle_cnt), 64'h3);
    check("t5_out_q",   64'(bus_b.out_q),      64'h1);

    // Asynchronous reset mid-flight.
    bus_a.in1 = 8'h3C; bus_a.in_valid = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    bus_a.in_valid = 1'b0;
    #1;
    check("t6_out_q",   64'(bus_a.out_q),       64'h00);
    check("t6_vld",     64'(bus_a.out_q_valid), 64'h0);
    check("t6_cnt",     64'(bus_a.toggle_cnt),  64'h0);
    check("t6_b_cnt",   64'(bus_b.toggle_cnt),  64'h0);
    bus_a.in1 = 8'h81;
    #1 check("t6_out_in_rst", 64'(bus_a.out), 64'h7E);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_no_late_vld", 64'(bus_a.out_q_valid), 64'h0);
      check("t6_no_late_q",   64'(bus_a.out_q),       64'h00);
    end

    // Mixed traffic checked by the model only.
    for (int i = 0; i < 16; i++) begin
      bus_a.in1      = 8'(i * 37 + 5);
      bus_a.in_valid = ((i % 3) != 2);
      bus_b.in1      = 1'(i >> 1);
      bus_b.in_valid = ((i % 4) != 3);
      @(negedge clk);
    end
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
